hc_csr_bank: RTL
================

Name: hc_csr_bank

Overview:
- Parametrised MMIO CSR bank for HardCloud accelerator AFUs. Successor to the fixed per-accelerator CSR blocks.
- Implements the AFU device feature header (DFH) and AFU ID, DSM base, control, and an N-entry buffer descriptor table with full-width sizes.
- Adds a start/done run state machine with status readback, a scratch register, and readback of every RW register.
- Sits between the CCI-P MMIO channels (c0 Rx, c2 Tx) and the accelerator core.

Parameters:
- NUM_BUFFERS, 4, number of buffer descriptors (1..16).
- SIZE_W, 64, buffer size field width; writes store data[SIZE_W-1:0] with no truncation to 32 bits.
- AFU_ID, 128'h0, 128-bit AFU UUID returned at AFU_ID_L/H.

Ports:
- clk  in  1  CCI-P clock.
- reset_n  in  1  asynchronous active-low reset.
- rx_mmio_channel  in  t_if_ccip_c0_Rx  MMIO read/write requests.
- tx_mmio_channel  out  t_if_ccip_c2_Tx  MMIO read responses.
- accel_done  in  1  one-cycle pulse from the core when a job completes.
- hc_dsm_base  out  t_ccip_clAddr  DSM base, cache-line address (written byte address >> 6).
- hc_control  out  32  control word; bit0 always reads 0.
- start_pulse  out  1  one-cycle job start.
- run_busy  out  1  high while in RUNNING.
- buf_addr  out  NUM_BUFFERS x t_ccip_clAddr  buffer addresses.
- buf_size  out  NUM_BUFFERS x SIZE_W  buffer sizes.

Behaviour:
- Register map, byte offsets. The MMIO header address field is the byte offset >> 2. Only 64-bit requests are decoded.
  - 0x000 DFH (RO): bits[63:60]=1, bit40=1, all other bits 0.
  - 0x008 AFU_ID_L (RO).
  - 0x010 AFU_ID_H (RO).
  - 0x018, 0x020 reserved (RO 0).
  - 0x100 DSM_BASE (RW). Stores data>>6; readback returns the stored value <<6.
  - 0x108 CONTROL (RW). Writing bit0=1 requests start; bit0 is not stored. Bits[31:1] are stored.
  - 0x110 STATUS (RO except W1C bits):
    - bit0 busy.
    - bit1 done: sticky, W1C.
    - bit2 start_err: sticky, W1C.
    - bits[15:8] NUM_BUFFERS.
  - 0x118 SCRATCH (RW, 64 bits).
  - 0x200+16*i BUF_ADDR[i] (RW).
  - 0x208+16*i BUF_SIZE[i] (RW).
  - Any other address reads 0; writes to it are ignored.
- Reads:
  - Response one cycle after mmioRdValid: tx mmioRdValid=1, tid copied from the request.
  - Unmapped and out-of-range buffer indices (i >= NUM_BUFFERS) read 0.
  - Back-to-back reads on consecutive cycles are each answered.
- Writes:
  - Take effect on the clock edge after mmioWrValid.
  - Register outputs update the same edge; readback in the next cycle reflects the new value.
  - Writes to RO registers and out-of-range buffers are ignored.
- Run FSM states: IDLE, RUNNING, DONE.
  - IDLE or DONE, CONTROL write with bit0=1: go to RUNNING, assert start_pulse for exactly 1 cycle, clear done.
  - RUNNING, CONTROL write with bit0=1: stay in RUNNING, no pulse, set start_err.
  - RUNNING and accel_done: go to DONE, set done.
  - accel_done in IDLE or DONE: ignored.
  - DONE and STATUS W1C of bit1: go to IDLE.
  - accel_done in the same cycle as a done W1C: set wins, done stays 1.
  - run_busy = (state == RUNNING).
- Reset (asynchronous, any time including mid-job):
  - State returns to IDLE.
  - All registers, outputs, status bits and tx mmioRdValid go to 0.
  - Any pending read response is dropped.

Optional Feature:
- Macro: HC_CSR_CYCLE_COUNTER_EN.
- When defined:
  - A 64-bit counter at 0x120 (RO) clears on each accepted start.
  - It increments every cycle in RUNNING and holds its value in DONE and IDLE.
  - It saturates at all-ones.
- When not defined: 0x120 reads 0 and no counter logic is built.

Test Plan:
- Read 0x000, 0x008, 0x010 with tid=0x1A5 and AFU_ID=128'hC000C966_0D82_4272_9AEF_FE5F84570612 -> one cycle later: 0x1000010000000000 (DFH), then AFU_ID[63:0], then AFU_ID[127:64], each with tid 0x1A5.
- Write BUF_SIZE[3]=0x0000_0001_0000_0040 (NUM_BUFFERS=4), then read it back -> full 64-bit value on buf_size[3] and in the response. Write BUF_ADDR[5]=0x1234 -> ignored, and a read of BUF_ADDR[5] returns 0.
- Write DSM_BASE=0x8000_0040 -> hc_dsm_base=0x2000001; readback returns 0x8000_0040.
- Write CONTROL=0x3 -> start_pulse for 1 cycle, busy=1, hc_control=0x2. Write CONTROL=0x1 again -> no pulse, STATUS=0x0405. accel_done -> STATUS=0x0406. Write STATUS=0x6 -> STATUS=0x0400.
- accel_done and a STATUS bit1 W1C in the same cycle while RUNNING -> done=1, state DONE.
- Assert reset_n=0 mid-RUNNING -> all outputs 0 asynchronously. After release, a read of 0x110 returns 0x0400. With HC_CSR_CYCLE_COUNTER_EN defined, a 10-cycle run reads 0x120 = 10.

Source files
------------

// File: rtl/hc_csr_bank.sv
// ---------------------------------------------------------------------------
// hc_csr_bank -- parametrised MMIO CSR bank for HardCloud accelerator AFUs.
//
// Decodes 64-bit CCI-P MMIO reads/writes and provides:
//   DFH, AFU ID, DSM base, control word, status (busy/done/start_err),
//   scratch, an NUM_BUFFERS-entry buffer descriptor table, and a
//   start/done run state machine (IDLE -> RUNNING -> DONE).
//
// Ports:
//   clk              CCI-P clock
//   reset_n          asynchronous active-low reset
//   rx_mmio_channel  c0 Rx: MMIO read/write requests (hdr is the MMIO request header)
//   tx_mmio_channel  c2 Tx: MMIO read responses, one cycle after the request
//   accel_done       one-cycle completion pulse from the accelerator core
//   hc_dsm_base      DSM base as cache-line address (written byte address >> 6)
//   hc_control       control word, bit0 always 0 (bit0 writes are start requests)
//   start_pulse      one-cycle job start
//   run_busy         high while the run FSM is in RUNNING
//   buf_addr         per-buffer cache-line addresses (written value, low 42 bits)
//   buf_size         per-buffer sizes, SIZE_W bits wide
//
// Optional feature: define HC_CSR_CYCLE_COUNTER_EN to build a saturating
// 64-bit run-cycle counter readable at byte offset 0x120.
//
// Handshake: MMIO has no backpressure. A request is taken on every clock edge
// where mmioRdValid or mmioWrValid is high; every read gets exactly one
// response (mmioRdValid with the request tid) on the following cycle.
// ---------------------------------------------------------------------------
package ccip_if_pkg;
    typedef logic [41:0] t_ccip_clAddr;
    typedef logic [15:0] t_ccip_mmioAddr;
    typedef logic [8:0]  t_ccip_tid;
    typedef logic [1:0]  t_ccip_mmioLen;   // 0: 4B, 1: 8B, 2: 64B

    typedef struct packed {
        t_ccip_mmioAddr address;           // byte offset >> 2
        t_ccip_mmioLen  length;
        logic           rsvd;
        t_ccip_tid      tid;
    } t_ccip_c0_ReqMmioHdr;

    typedef struct packed {
        t_ccip_c0_ReqMmioHdr hdr;
        logic [511:0]        data;
        logic                rspValid;
        logic                mmioRdValid;
        logic                mmioWrValid;
    } t_if_ccip_c0_Rx;

    typedef struct packed {
        t_ccip_tid tid;
    } t_ccip_c2_RspMmioHdr;

    typedef struct packed {
        t_ccip_c2_RspMmioHdr hdr;
        logic                mmioRdValid;
        logic [63:0]         data;
    } t_if_ccip_c2_Tx;
endpackage

module hc_csr_bank
    import ccip_if_pkg::*;
#(
    parameter int           NUM_BUFFERS = 4,
    parameter int           SIZE_W      = 64,
    parameter logic [127:0] AFU_ID      = 128'h0
) (
    input  logic                                clk,
    input  logic                                reset_n,
    input  t_if_ccip_c0_Rx                      rx_mmio_channel,
    output t_if_ccip_c2_Tx                      tx_mmio_channel,
    input  logic                                accel_done,
    output t_ccip_clAddr                        hc_dsm_base,
    output logic [31:0]                         hc_control,
    output logic                                start_pulse,
    output logic                                run_busy,
    output t_ccip_clAddr [NUM_BUFFERS-1:0]      buf_addr,
    output logic [NUM_BUFFERS-1:0][SIZE_W-1:0]  buf_size
);

    // Register addresses in MMIO address units (byte offset >> 2).
    localparam logic [15:0] A_DFH     = 16'h0000;
    localparam logic [15:0] A_AFU_L   = 16'h0002;
    localparam logic [15:0] A_AFU_H   = 16'h0004;
    localparam logic [15:0] A_DSM     = 16'h0040;
    localparam logic [15:0] A_CTRL    = 16'h0042;
    localparam logic [15:0] A_STATUS  = 16'h0044;
    localparam logic [15:0] A_SCRATCH = 16'h0046;
`ifdef HC_CSR_CYCLE_COUNTER_EN
    localparam logic [15:0] A_CYCLES  = 16'h0048;
`endif

    localparam logic [63:0] DFH_VALUE     = 64'h1000_0100_0000_0000;
    localparam logic [7:0]  NUM_BUF_FIELD = 8'(NUM_BUFFERS);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_RUNNING = 2'd1,
        S_DONE    = 2'd2
    } run_state_t;

    t_ccip_c0_ReqMmioHdr req_hdr;
    logic [63:0]         wdata;
    logic                req_64;
    logic                wr_en;
    logic                buf_hit;
    logic                buf_sel_size;
    logic [3:0]          buf_idx;
    logic                start_req;
    logic                clr_done;
    logic                clr_err;
    run_state_t          state;
    logic                start_err;
    logic [63:0]         scratch;
    logic [63:0]         rd_data;

    assign req_hdr = rx_mmio_channel.hdr;
    assign wdata   = rx_mmio_channel.data[63:0];

    // Only 8-byte, 8-byte-aligned requests address a register.
    assign req_64 = (req_hdr.length == 2'b01) && !req_hdr.address[0];
    assign wr_en  = rx_mmio_channel.mmioWrValid && req_64;

    // Buffer table spans byte offsets 0x200..0x2FF: 16-byte slots, address
    // word at +0 and size word at +8.
    assign buf_hit      = (req_hdr.address[15:6] == 10'h002);
    assign buf_idx      = req_hdr.address[5:2];
    assign buf_sel_size = req_hdr.address[1];

    assign start_req = wr_en && (req_hdr.address == A_CTRL) && wdata[0];
    assign clr_done  = wr_en && (req_hdr.address == A_STATUS) && wdata[1];
    assign clr_err   = wr_en && (req_hdr.address == A_STATUS) && wdata[2];

    // Upper payload bits, rspValid and the reserved header bit are not used.
    logic unused_inputs;
    assign unused_inputs = ^{rx_mmio_channel.data[511:64], rx_mmio_channel.rspValid, req_hdr.rsvd};

    // Plain RW registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hc_dsm_base <= '0;
            hc_control  <= '0;
            scratch     <= '0;
            buf_addr    <= '0;
            buf_size    <= '0;
        end else if (wr_en) begin
            case (req_hdr.address)
                A_DSM:     hc_dsm_base <= wdata[47:6];
                A_CTRL:    hc_control  <= {wdata[31:1], 1'b0};
                A_SCRATCH: scratch     <= wdata;
                default:   ;
            endcase
            if (buf_hit) begin
                for (int i = 0; i < NUM_BUFFERS; i++) begin
                    if (buf_idx == 4'(i)) begin
                        if (buf_sel_size) buf_size[i] <= wdata[SIZE_W-1:0];
                        else              buf_addr[i] <= wdata[41:0];
                    end
                end
            end
        end
    end

    // Run FSM. The done status bit is exactly "state is DONE": it is set on
    // completion, cleared by a new start or by W1C (which returns to IDLE).
    // A W1C arriving with accel_done while RUNNING has no effect, so the
    // completion wins.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= S_IDLE;
            start_pulse <= 1'b0;
            run_busy    <= 1'b0;
            start_err   <= 1'b0;
        end else begin
            start_pulse <= 1'b0;
            if (clr_err) start_err <= 1'b0;
            case (state)
                S_IDLE, S_DONE: begin
                    if (start_req) begin
                        state       <= S_RUNNING;
                        start_pulse <= 1'b1;
                        run_busy    <= 1'b1;
                    end else if (state == S_DONE && clr_done) begin
                        state <= S_IDLE;
                    end
                end
                S_RUNNING: begin
                    if (start_req) start_err <= 1'b1;
                    if (accel_done) begin
                        state    <= S_DONE;
                        run_busy <= 1'b0;
                    end
                end
                default: begin
                    state    <= S_IDLE;
                    run_busy <= 1'b0;
                end
            endcase
        end
    end

`ifdef HC_CSR_CYCLE_COUNTER_EN
    logic [63:0] cycle_cnt;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cycle_cnt <= '0;
        end else if (start_req && state != S_RUNNING) begin
            cycle_cnt <= '0;
        end else if (state == S_RUNNING && cycle_cnt != '1) begin
            cycle_cnt <= cycle_cnt + 64'd1;
        end
    end
`endif

    // Read data mux, sampled into the response register.
    always_comb begin
        rd_data = '0;
        if (req_64) begin
            case (req_hdr.address)
                A_DFH:     rd_data = DFH_VALUE;
                A_AFU_L:   rd_data = AFU_ID[63:0];
                A_AFU_H:   rd_data = AFU_ID[127:64];
                A_DSM:     rd_data = {16'h0, hc_dsm_base, 6'h0};
                A_CTRL:    rd_data = {32'h0, hc_control};
                A_STATUS:  rd_data = {48'h0, NUM_BUF_FIELD, 5'h0, start_err, (state == S_DONE), run_busy};
                A_SCRATCH: rd_data = scratch;
`ifdef HC_CSR_CYCLE_COUNTER_EN
                A_CYCLES:  rd_data = cycle_cnt;
`endif
                default:   rd_data = '0;
            endcase
            if (buf_hit) begin
                for (int i = 0; i < NUM_BUFFERS; i++) begin
                    if (buf_idx == 4'(i)) begin
                        rd_data = buf_sel_size ? 64'(buf_size[i]) : 64'(buf_addr[i]);
                    end
                end
            end
        end
    end

    // Read response: one cycle after the request, tid echoed.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tx_mmio_channel <= '0;
        end else begin
            tx_mmio_channel.mmioRdValid <= rx_mmio_channel.mmioRdValid;
            if (rx_mmio_channel.mmioRdValid) begin
                tx_mmio_channel.hdr.tid <= req_hdr.tid;
                tx_mmio_channel.data    <= rd_data;
            end
        end
    end

endmodule
